// File: rtl/jk_pkg.sv
// Shared JK definitions: {J,K} encodings, a width helper and the parameter range check.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_t;

    localparam int JK_MAX_WIDTH = 8;

    function automatic int clog2(input int v);
        int r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return r;
    endfunction

    // Legal configurations: 1..8 bits, and MODULUS must fit in WIDTH bits.
    function automatic bit params_ok(input int width, input int modulus);
        return (width >= 1) && (width <= JK_MAX_WIDTH) &&
               (modulus >= 2) && (clog2(modulus) <= width);
    endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop with synchronous active-high reset; Q_n is held in its own register.
module jk_cell
    import jk_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Q_n
);

    logic q_nx;

    always_comb begin
        q_nx = Q;
        case (jk_t'({J, K}))
            JK_HOLD:   q_nx = Q;
            JK_RESET:  q_nx = 1'b0;
            JK_SET:    q_nx = 1'b1;
            JK_TOGGLE: q_nx = ~Q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q   <= 1'b0;
            Q_n <= 1'b1;
        end else begin
            Q   <= q_nx;
            Q_n <= ~q_nx;
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from a row of JK cells driven in toggle form.
// Optional parallel load (LOAD/D ports) is enabled by defining JK_CNT_LOAD_EN.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             UP,
`ifdef JK_CNT_LOAD_EN
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_n,
    output logic             TC,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    generate
        if (!params_ok(WIDTH, MODULUS)) begin : g_bad_params
            $error("jk_mod_counter: illegal WIDTH/MODULUS combination");
        end
    endgenerate

    logic             at_max, at_zero, ld_wrap_blk;
    logic [WIDTH-1:0] nxt, jv, kv;

    assign at_max  = (Q == MAXV);
    assign at_zero = (Q == '0);

    always_comb begin
        nxt = Q;
        if (UP) nxt = at_max  ? '0   : Q + WIDTH'(1);
        else    nxt = at_zero ? MAXV : Q - WIDTH'(1);
    end

    assign TC = ~RST & EN & ((UP & at_max) | (~UP & at_zero));

`ifdef JK_CNT_LOAD_EN
    localparam logic [WIDTH:0] MODV = (WIDTH+1)'(MODULUS);
    logic [WIDTH-1:0] ld_v;

    // Out-of-range load values saturate so no illegal count is ever stored.
    assign ld_v        = ({1'b0, D} >= MODV) ? MAXV : D;
    assign ld_wrap_blk = LOAD;
`else
    assign ld_wrap_blk = 1'b0;
`endif

    always_comb begin
        jv = '0;
        kv = '0;
`ifdef JK_CNT_LOAD_EN
        if (LOAD) begin
            jv = ld_v;
            kv = ~ld_v;
        end else
`endif
        if (EN) begin
            jv = Q ^ nxt;
            kv = Q ^ nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) WRAP <= 1'b0;
        else     WRAP <= TC & ~ld_wrap_blk;
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            jk_cell u_cell (
                .CLK (CLK),
                .RST (RST),
                .J   (jv[i]),
                .K   (kv[i]),
                .Q   (Q[i]),
                .Q_n (Q_n[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_jk_mod_counter.sv
// Table-driven bench for jk_mod_counter (mod-10 main instance, mod-2 instance for back-to-back wraps).
module tb_jk_mod_counter;

    typedef struct {
        logic       rst, en, up, ld;
        logic [3:0] d;
        logic       tc;
        logic [3:0] q;
        logic       w;
        string      tag;
    } vec_t;

    typedef struct packed {
        logic [3:0] q;
        logic       w;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST, EN, UP, LOAD;
    logic [3:0] D;
    logic [3:0] Q, Q_n;
    logic       TC, WRAP;

    logic       rst2, en2, up2, load2;
    logic [0:0] d2, q2, qn2;
    logic       tc2, w2;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t tbl[$];
    exp_t sb[$];

    always #5 CLK = ~CLK;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .UP(UP),
`ifdef JK_CNT_LOAD_EN
        .LOAD(LOAD), .D(D),
`endif
        .Q(Q), .Q_n(Q_n), .TC(TC), .WRAP(WRAP)
    );

    jk_mod_counter #(.WIDTH(1), .MODULUS(2)) dut2 (
        .CLK(CLK), .RST(rst2), .EN(en2), .UP(up2),
`ifdef JK_CNT_LOAD_EN
        .LOAD(load2), .D(d2),
`endif
        .Q(q2), .Q_n(qn2), .TC(tc2), .WRAP(w2)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rst, en, up, ld, input logic [3:0] d,
                       input logic tc, input logic [3:0] q, input logic w, input string tag);
        tbl.push_back('{rst:rst, en:en, up:up, ld:ld, d:d, tc:tc, q:q, w:w, tag:tag});
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        RST = v.rst; EN = v.en; UP = v.up; LOAD = v.ld; D = v.d;
        #1;
        chk({v.tag, ".tc"}, {7'd0, TC}, {7'd0, v.tc});
        sb.push_back('{q:v.q, w:v.w});
        @(posedge CLK); #1;
        e = sb.pop_front();
        chk({v.tag, ".q"},    {4'd0, Q},    {4'd0, e.q});
        chk({v.tag, ".qn"},   {4'd0, Q_n},  {4'd0, ~e.q});
        chk({v.tag, ".wrap"}, {7'd0, WRAP}, {7'd0, e.w});
        @(negedge CLK);
    endtask

    task automatic step2(input logic rst, en, up, tc, q, w, input string tag);
        exp_t e;
        rst2 = rst; en2 = en; up2 = up;
        #1;
        chk({tag, ".tc"}, {7'd0, tc2}, {7'd0, tc});
        sb.push_back('{q:{3'd0, q}, w:w});
        @(posedge CLK); #1;
        e = sb.pop_front();
        chk({tag, ".q"},    {7'd0, q2},   {4'd0, e.q});
        chk({tag, ".qn"},   {7'd0, qn2},  {7'd0, ~e.q[0]});
        chk({tag, ".wrap"}, {7'd0, w2},   {7'd0, e.w});
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; UP = 1'b1; LOAD = 1'b0; D = 4'd0;
        rst2 = 1'b1; en2 = 1'b0; up2 = 1'b1; load2 = 1'b0; d2 = 1'b0;

        // reset, then idle
        add(1,0,1,0,0, 0,0,0, "rst0");
        add(1,0,1,0,0, 0,0,0, "rst1");
        for (int i = 0; i < 3; i++) add(0,0,1,0,0, 0,0,0, "idle");
        // count up 12 edges: 1..9,0,1,2
        add(0,1,1,0,0, 0,1,0, "up0");  add(0,1,1,0,0, 0,2,0, "up1");
        add(0,1,1,0,0, 0,3,0, "up2");  add(0,1,1,0,0, 0,4,0, "up3");
        add(0,1,1,0,0, 0,5,0, "up4");  add(0,1,1,0,0, 0,6,0, "up5");
        add(0,1,1,0,0, 0,7,0, "up6");  add(0,1,1,0,0, 0,8,0, "up7");
        add(0,1,1,0,0, 0,9,0, "up8");  add(0,1,1,0,0, 1,0,1, "upwrap");
        add(0,1,1,0,0, 0,1,0, "up10"); add(0,1,1,0,0, 0,2,0, "up11");
        // down to 0, then wrap down to 9,8,7
        add(0,1,0,0,0, 0,1,0, "dn0");  add(0,1,0,0,0, 0,0,0, "dn1");
        add(0,1,0,0,0, 1,9,1, "dnwrap");
        add(0,1,0,0,0, 0,8,0, "dn3");  add(0,1,0,0,0, 0,7,0, "dn4");
        add(0,1,0,0,0, 0,6,0, "dn5");  add(0,1,0,0,0, 0,5,0, "dn6");
        // direction flips on consecutive edges
        add(0,1,1,0,0, 0,6,0, "dir0"); add(0,1,0,0,0, 0,5,0, "dir1");
        add(0,1,1,0,0, 0,6,0, "dir2");
        for (int i = 0; i < 4; i++) add(0,0,1,0,0, 0,6,0, "hold");
        // reset mid-count overrides enable
        add(0,1,1,0,0, 0,7,0, "up7b");
        add(1,1,1,0,0, 0,0,0, "rstmid");
        add(0,1,1,0,0, 0,1,0, "res1"); add(0,1,1,0,0, 0,2,0, "res2");
        // reach 9, check TC gated by EN, then reset while terminal
        for (int i = 3; i <= 9; i++) add(0,1,1,0,0, 0,4'(i),0, "climb");
        add(0,0,1,0,0, 0,9,0, "tcen0");
        add(0,1,0,0,0, 0,8,0, "dn9");  add(0,1,1,0,0, 0,9,0, "up9");
        add(1,1,1,0,0, 0,0,0, "rsttc");
`ifdef JK_CNT_LOAD_EN
        add(0,1,1,1,4,  0,4,0, "ld4");
        add(0,1,1,1,13, 0,9,0, "ld13");
        add(0,1,1,1,9,  1,9,0, "ld9");
        add(0,1,1,0,0,  1,0,1, "ldwrap");
        add(0,0,1,1,2,  0,2,0, "ldnoen");
`endif

        @(negedge CLK);
        foreach (tbl[i]) step(tbl[i]);

        // mod-2 instance: alternating direction wraps on every edge
        step2(1,0,1, 0,0,0, "m2rst");
        step2(0,1,0, 1,1,1, "m2w0");
        step2(0,1,1, 1,0,1, "m2w1");
        step2(0,1,0, 1,1,1, "m2w2");
        step2(0,1,1, 1,0,1, "m2w3");
        step2(0,0,1, 0,0,0, "m2hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
